// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit.
// Two-process FSM: a state register plus combinational next-state and output
// decode. The outputs depend on the state and on the held op/funct fields.
// The one exception is PCWr in BRANCH, which follows Zero directly.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       OF,
  output logic       PCWr,
  output logic [1:0] PCSrc,
  output logic       IRWr,
  output logic       RegWr,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       ExtOp,
  output logic [1:0] ALUctr,
  output logic       addi,
  output logic       MemWr,
  output logic       MemtoReg,
  output logic       done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC_R  = 4'd2,
    EXEC_I  = 4'd3,
    MEM_ADR = 4'd4,
    MEM_RD  = 4'd5,
    MEM_WR  = 4'd6,
    WB_MEM  = 4'd7,
    WB_ALU  = 4'd8,
    BRANCH  = 4'd9,
    JUMP    = 4'd10
  } state_t;

  state_t state_reg, state_next;
  logic   of_q;

  // Instruction decode from the held IR fields
  logic is_r, is_addu, is_subu, is_ori, is_lui, is_addi, is_lw, is_sw, is_beq, is_j;
  assign is_r    = (op == 6'b000000);
  assign is_addu = is_r && (funct == 6'b100001);
  assign is_subu = is_r && (funct == 6'b100011);
  assign is_ori  = (op == 6'b001101);
  assign is_lui  = (op == 6'b001111);
  assign is_addi = (op == 6'b001000);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_beq  = (op == 6'b000100);
  assign is_j    = (op == 6'b000010);

  assign state = state_reg;

  // State register and the addi overflow flag.
  // of_q captures OF only when leaving EXEC_I for an addi, so it is valid in WB_ALU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FETCH;
      of_q      <= 1'b0;
    end else begin
      state_reg <= state_next;
      of_q      <= (state_reg == EXEC_I && is_addi) ? OF : 1'b0;
    end
  end

  // Next-state and output decode. Reset gates every write enable and done.
  always_comb begin
    state_next = FETCH;
    PCWr       = 1'b0;
    PCSrc      = 2'b00;
    IRWr       = 1'b0;
    RegWr      = 1'b0;
    RegDst     = 1'b0;
    ALUSrc     = 1'b0;
    ExtOp      = 1'b0;
    ALUctr     = 2'b00;
    addi       = 1'b0;
    MemWr      = 1'b0;
    MemtoReg   = 1'b0;
    done       = 1'b0;
    case (state_reg)
      FETCH: begin
        IRWr       = 1'b1;
        PCWr       = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        if (is_addu || is_subu)              state_next = EXEC_R;
        else if (is_ori || is_lui || is_addi) state_next = EXEC_I;
        else if (is_lw || is_sw)             state_next = MEM_ADR;
        else if (is_beq)                     state_next = BRANCH;
        else if (is_j)                       state_next = JUMP;
        else begin
          // Unsupported instruction retires here as a NOP
          state_next = FETCH;
          done       = 1'b1;
        end
      end
      EXEC_R: begin
        ALUctr     = is_subu ? 2'b01 : 2'b00;
        state_next = WB_ALU;
      end
      EXEC_I: begin
        ALUSrc = 1'b1;
        if (is_ori) begin
          ALUctr = 2'b10;
        end else if (is_lui) begin
          ALUctr = 2'b11;
        end else begin
          ExtOp = 1'b1;
          addi  = 1'b1;
        end
        state_next = WB_ALU;
      end
      WB_ALU: begin
        RegDst     = is_r;
        RegWr      = !(is_addi && of_q);
        done       = 1'b1;
        state_next = FETCH;
      end
      MEM_ADR: begin
        ALUSrc     = 1'b1;
        ExtOp      = 1'b1;
        state_next = is_sw ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        state_next = WB_MEM;
      end
      WB_MEM: begin
        MemtoReg   = 1'b1;
        RegWr      = 1'b1;
        done       = 1'b1;
        state_next = FETCH;
      end
      MEM_WR: begin
        MemWr      = 1'b1;
        done       = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUctr     = 2'b01;
        PCSrc      = 2'b01;
        PCWr       = Zero;
        done       = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        PCWr       = 1'b1;
        done       = 1'b1;
        state_next = FETCH;
      end
      default: begin
        // Illegal code: recover to FETCH with nothing enabled
        state_next = FETCH;
      end
    endcase
    if (reset) begin
      PCWr  = 1'b0;
      IRWr  = 1'b0;
      RegWr = 1'b0;
      MemWr = 1'b0;
      done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Per-cycle expectations are queued when
// an instruction is issued and popped as the FSM steps through its states.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       Zero, OF;
  logic       PCWr, IRWr, RegWr, RegDst, ALUSrc, ExtOp, addi, MemWr, MemtoReg, done;
  logic [1:0] PCSrc, ALUctr;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .Zero(Zero), .OF(OF),
    .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .RegWr(RegWr), .RegDst(RegDst),
    .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ALUctr(ALUctr), .addi(addi),
    .MemWr(MemWr), .MemtoReg(MemtoReg), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // Output bit positions in the packed compare word
  localparam logic [13:0] PCWR = 14'h2000, PC_BR = 14'h0800, PC_J = 14'h1000,
                          IRWR = 14'h0400, REGWR = 14'h0200, REGDST = 14'h0100,
                          ALUSRC = 14'h0080, EXTOP = 14'h0040, A_SUB = 14'h0010,
                          A_OR = 14'h0020, A_PASS = 14'h0030, ADDI = 14'h0008,
                          MEMWR = 14'h0004, M2R = 14'h0002, DONE = 14'h0001;
  localparam logic [13:0] ALL = 14'h3FFF;
  localparam logic [13:0] F_OUT = PCWR | IRWR;

  typedef struct packed {
    logic [3:0]  st;
    logic [13:0] outs;
    logic [13:0] mask;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  int    step = 0;
  string tag = "reset";

  logic [13:0] obs;
  assign obs = {PCWr, PCSrc, IRWr, RegWr, RegDst, ALUSrc, ExtOp, ALUctr, addi, MemWr, MemtoReg, done};

  task automatic push(input logic [3:0] st, input logic [13:0] o, input logic [13:0] m);
    exp_t e;
    e.st = st; e.outs = o; e.mask = m;
    sb.push_back(e);
  endtask

  // Compare the current DUT outputs against the oldest queued expectation
  task automatic check_now();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (state === e.st) else begin
      failures++;
      $error("FAIL %s step%0d state: got %0d expected %0d", tag, step, state, e.st);
    end
    checks++;
    assert ((obs & e.mask) === (e.outs & e.mask)) else begin
      failures++;
      $error("FAIL %s step%0d outputs: got %h expected %h", tag, step, obs & e.mask, e.outs & e.mask);
    end
    step++;
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      check_now();
      @(negedge clk); #1;
    end
  endtask

  task automatic issue(input string t, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic v);
    tag = t; step = 0;
    op = o; funct = f; Zero = z; OF = v;
    push(4'd0, F_OUT, ALL);
    push(4'd1, 14'h0, ALL);
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; op = 6'd0; funct = 6'd0; Zero = 1'b0; OF = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    // Held in reset across edges: FETCH with no enables
    push(4'd0, 14'h0, ALL);
    check_now();
    @(negedge clk);
    reset = 1'b0;
    #1;

    issue("subu", 6'b000000, 6'b100011, 1'b0, 1'b0);
    push(4'd2, A_SUB, ALL);
    push(4'd8, REGWR | REGDST | DONE, ALL);
    drain();

    issue("addu", 6'b000000, 6'b100001, 1'b0, 1'b0);
    push(4'd2, 14'h0, ALL);
    push(4'd8, REGWR | REGDST | DONE, ALL);
    drain();

    issue("ori", 6'b001101, 6'b010101, 1'b0, 1'b0);
    push(4'd3, ALUSRC | A_OR, ALL);
    push(4'd8, REGWR | DONE, ALL);
    drain();

    issue("lui", 6'b001111, 6'b000000, 1'b0, 1'b0);
    push(4'd3, ALUSRC | A_PASS, ALL & ~EXTOP);
    push(4'd8, REGWR | DONE, ALL);
    drain();

    issue("addi_of", 6'b001000, 6'b000000, 1'b0, 1'b1);
    push(4'd3, ALUSRC | EXTOP | ADDI, ALL);
    push(4'd8, DONE, ALL);
    drain();

    issue("addi_ok", 6'b001000, 6'b000000, 1'b0, 1'b0);
    push(4'd3, ALUSRC | EXTOP | ADDI, ALL);
    push(4'd8, REGWR | DONE, ALL);
    drain();

    issue("lw", 6'b100011, 6'b000000, 1'b0, 1'b0);
    push(4'd4, ALUSRC | EXTOP, ALL);
    push(4'd5, 14'h0, ALL);
    push(4'd7, M2R | REGWR | DONE, ALL);
    drain();

    issue("sw", 6'b101011, 6'b000000, 1'b0, 1'b0);
    push(4'd4, ALUSRC | EXTOP, ALL);
    push(4'd6, MEMWR | DONE, ALL);
    drain();

    issue("beq_taken", 6'b000100, 6'b000000, 1'b1, 1'b0);
    push(4'd9, PCWR | PC_BR | A_SUB | DONE, ALL);
    drain();

    issue("beq_not", 6'b000100, 6'b000000, 1'b0, 1'b0);
    push(4'd9, PC_BR | A_SUB | DONE, ALL);
    drain();

    issue("j", 6'b000010, 6'b000000, 1'b0, 1'b0);
    push(4'd10, PCWR | PC_J | DONE, ALL);
    drain();

    // Unsupported opcode retires from DECODE as a NOP
    tag = "bad_op"; step = 0; op = 6'b111111; funct = 6'd0;
    push(4'd0, F_OUT, ALL);
    push(4'd1, DONE, ALL);
    drain();

    // R-type with an unsupported funct behaves the same way
    tag = "bad_funct"; step = 0; op = 6'b000000; funct = 6'b100000;
    push(4'd0, F_OUT, ALL);
    push(4'd1, DONE, ALL);
    drain();

    // Asynchronous reset in MEM_ADR of a store: no MemWr may follow
    issue("sw_reset", 6'b101011, 6'b000000, 1'b0, 1'b0);
    drain();
    push(4'd4, ALUSRC | EXTOP, ALL);
    check_now();
    #1 reset = 1'b1;
    #1;
    push(4'd0, 14'h0, ALL);
    check_now();
    @(negedge clk); #1;
    push(4'd0, 14'h0, ALL);
    check_now();
    @(negedge clk);
    reset = 1'b0;
    #1;

    issue("j_after_reset", 6'b000010, 6'b000000, 1'b0, 1'b0);
    push(4'd10, PCWR | PC_J | DONE, ALL);
    push(4'd0, F_OUT, ALL);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 No parameters; all encodings are fixed by this document.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  opcode field of the instruction register (IR[31:26]); valid from DECODE onward.
REQ-005 funct  input  6  function field (IR[5:0]); valid from DECODE onward.
REQ-006 Zero  input  1  ALU equality flag (A==B), combinational from ALU.
REQ-007 OF  input  1  ALU addi-overflow flag, combinational from ALU.
REQ-008 PCWr  output  1  PC write enable.
REQ-009 PCSrc  output  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target.
REQ-010 IRWr  output  1  instruction register write enable.
REQ-011 RegWr  output  1  register file write enable.
REQ-012 RegDst  output  1  write-register select: 0 rt, 1 rd.
REQ-013 ALUSrc  output  1  ALU B operand: 0 register rt, 1 extended immediate.
REQ-014 ExtOp  output  1  immediate extension: 1 sign, 0 zero.
REQ-015 ALUctr  output  2  ALU op: 00 add, 01 sub, 10 or, 11 pass B.
REQ-016 addi  output  1  asserted while an addi is executing, enabling ALU overflow detection.
REQ-017 MemWr  output  1  data memory write enable.
REQ-018 MemtoReg  output  1  register write data: 0 ALU result register, 1 memory data register.
REQ-019 done  output  1  one-cycle pulse in the final state of every instruction.
REQ-020 state  output  4  current state encoding, for debug/verification.

Function
REQ-021 States and encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADR=4, MEM_RD=5, MEM_WR=6, WB_MEM=7, WB_ALU=8, BRANCH=9, JUMP=10; codes 11-15 are illegal.
REQ-022 Decoded instructions: R-type (op 000000) addu (funct 100001) and subu (funct 100011); ori 001101; lui 001111; addi 001000; lw 100011; sw 101011; beq 000100; j 000010.
REQ-023 FETCH: IRWr=1, PCWr=1, PCSrc=00; next state DECODE.
REQ-024 DECODE transitions: R-type addu/subu -> EXEC_R; ori/lui/addi -> EXEC_I; lw/sw -> MEM_ADR; beq -> BRANCH; j -> JUMP.
REQ-025 DECODE with an unsupported op, or an R-type with an unsupported funct -> FETCH, with done=1 and no write enable asserted (treated as NOP).
REQ-026 EXEC_R: ALUSrc=0, ALUctr=00 for addu, 01 for subu; next state WB_ALU.
REQ-027 EXEC_I: ALUSrc=1; ori: ExtOp=0, ALUctr=10; lui: ALUctr=11 (ExtOp don't-care); addi: ExtOp=1, ALUctr=00, addi=1; next state WB_ALU.
REQ-028 EXEC_I for addi SHALL register OF into internal flag of_q at the clock edge that leaves EXEC_I; of_q SHALL be cleared in every other state.
REQ-029 WB_ALU: RegDst=1 for R-type, otherwise 0; MemtoReg=0; RegWr=1, except RegWr=0 when the instruction is addi and of_q=1; done=1; next state FETCH.
REQ-030 MEM_ADR: ALUSrc=1, ExtOp=1, ALUctr=00; next state MEM_RD for lw, MEM_WR for sw.
REQ-031 MEM_RD -> WB_MEM; WB_MEM: RegDst=0, MemtoReg=1, RegWr=1, done=1; next state FETCH.
REQ-032 MEM_WR: MemWr=1, done=1; next state FETCH.
REQ-033 BRANCH: ALUSrc=0, ALUctr=01, PCSrc=01, PCWr=Zero (combinational), done=1; next state FETCH.
REQ-034 JUMP: PCSrc=10, PCWr=1, done=1; next state FETCH.
REQ-035 All outputs other than the BRANCH PCWr term are Moore-decoded from state and the held op/funct. In any state where an output is not listed it is 0; ALUctr defaults to 00.
REQ-036 Cycle counts: R-type/ori/lui/addi 4 cycles; lw 5; sw 4; beq 3; j 3.
REQ-037 An illegal state code SHALL transition to FETCH on the next edge, with all write enables 0.
REQ-038 At most one of IRWr, RegWr and MemWr is 1 in any cycle.

Reset
REQ-039 reset=1 SHALL force state=FETCH and of_q=0 immediately, independent of clk; the block SHALL hold FETCH while reset is high.
REQ-040 While reset=1, all write enables (PCWr, IRWr, RegWr, MemWr) and done SHALL be 0. The first FETCH actions occur on the first rising edge after deassertion.
REQ-041 Reset asserted mid-instruction SHALL abandon that instruction; no write enable from the abandoned instruction SHALL appear after reset.

Verification
REQ-042 op=000000, funct=100011 (subu) -> state sequence 0,1,2,8; ALUctr=01 in state 2; RegWr=1 and RegDst=1 in state 8; done pulses once.
REQ-043 op=001000 (addi) with OF=1 in EXEC_I -> RegWr=0 in WB_ALU; repeat with OF=0 -> RegWr=1; addi=1 only in state 3.
REQ-044 op=000100 (beq) with Zero=1 -> PCWr=1, PCSrc=01 in state 9; with Zero=0 -> PCWr=0; both cases return to FETCH after 3 cycles.
REQ-045 op=100011 (lw) -> states 0,1,4,5,7, 5 cycles; MemtoReg=1 and RegWr=1 only in state 7; op=101011 (sw) -> MemWr=1 only in state 6.
REQ-046 Assert reset asynchronously in MEM_ADR of an sw -> state=0 before the next edge; MemWr never asserted; after release, normal fetch resumes.
REQ-047 op=111111 -> DECODE returns to FETCH with done=1 and no write enables; the next instruction executes normally.
